// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the hazard/forwarding unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  localparam int unsigned NREG_D     = 32;
  localparam int unsigned ZERO_REG_D = 31;
  localparam int unsigned NSRC_D     = 2;
  localparam int unsigned MAXLAT_D   = 4;

endpackage

// File: rtl/hazard_fwd_unit_fwd_lane.sv
// One EX operand forwarding select lane; EX_MEM result takes priority over MEM_WB.
module fwd_lane
  import hazard_pkg::*;
#(
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = ZERO_REG_D
) (
  input  logic [AW-1:0] ex_src,
  input  logic [AW-1:0] ex_mem_rd,
  input  logic          ex_mem_regwrite,
  input  logic [AW-1:0] mem_wb_rd,
  input  logic          mem_wb_regwrite,
  output fwd_sel_e      sel
);

  always_comb begin
    sel = FWD_REG;
    if (ex_mem_regwrite && (ex_mem_rd != AW'(ZERO_REG)) && (ex_mem_rd == ex_src)) begin
      sel = FWD_EXMEM;
    end else if (mem_wb_regwrite && (mem_wb_rd != AW'(ZERO_REG)) && (mem_wb_rd == ex_src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// EX operand forwarding plus per-register pending-write scoreboard driving the ID stall.
// Optional stall statistics counter enabled by HAZARD_STATS_EN.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NREG     = NREG_D,
  parameter int unsigned ZERO_REG = ZERO_REG_D,
  parameter int unsigned NSRC     = NSRC_D,
  parameter int unsigned MAXLAT   = MAXLAT_D,
  localparam int unsigned AW      = $clog2(NREG),
  localparam int unsigned LW      = $clog2(MAXLAT + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [NSRC*AW-1:0] id_src,
  input  logic [NSRC-1:0]    id_src_used,
  input  logic [AW-1:0]      id_rd,
  input  logic               id_regwrite,
  input  logic [LW-1:0]      id_lat,
  input  logic               flush,
  input  logic [NSRC*AW-1:0] ex_src,
  input  logic [AW-1:0]      ex_mem_rd,
  input  logic [AW-1:0]      mem_wb_rd,
  input  logic               ex_mem_regwrite,
  input  logic               mem_wb_regwrite,
  output logic               stall,
  output logic [NSRC*2-1:0]  fwd_sel,
  output logic               busy,
  output logic [31:0]        stall_cycles
);

  logic [NREG-1:0][LW-1:0] pend_q, pend_d;
  logic [LW-1:0]           lat_clamped;
  logic                    issue;
  logic                    src_hit;

  always_comb begin
    src_hit = 1'b0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (id_src_used[k] && (id_src[k*AW +: AW] == AW'(r)) && (r != ZERO_REG)
            && (pend_q[r] != '0)) begin
          src_hit = 1'b1;
        end
      end
    end
    stall = id_valid & src_hit;
    busy  = |pend_q;
  end

  // A new producer overwrites the count outright so the youngest writer sets the wait.
  always_comb begin
    lat_clamped = (id_lat > LW'(MAXLAT)) ? LW'(MAXLAT) : id_lat;
    issue       = id_valid & ~stall & ~flush;
    pend_d      = pend_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (issue && id_regwrite && (id_rd == AW'(r)) && (r != ZERO_REG)) begin
        pend_d[r] = lat_clamped;
      end else if (pend_q[r] != '0) begin
        pend_d[r] = pend_q[r] - LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NSRC; k++) begin : g_lane
    fwd_sel_e lane_sel;

    fwd_lane #(
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_lane (
      .ex_src          (ex_src[k*AW +: AW]),
      .ex_mem_rd       (ex_mem_rd),
      .ex_mem_regwrite (ex_mem_regwrite),
      .mem_wb_rd       (mem_wb_rd),
      .mem_wb_regwrite (mem_wb_regwrite),
      .sel             (lane_sel)
    );

    assign fwd_sel[k*2 +: 2] = lane_sel;
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: forwarding vector table plus scoreboard sequences.
module tb_hazard_fwd_unit;
  import hazard_pkg::*;

  localparam int unsigned AW   = 5;
  localparam int unsigned LW   = 3;
  localparam int unsigned NSRC = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [NSRC*AW-1:0] id_src;
  logic [NSRC-1:0]   id_src_used;
  logic [AW-1:0]     id_rd;
  logic              id_regwrite;
  logic [LW-1:0]     id_lat;
  logic              flush;
  logic [NSRC*AW-1:0] ex_src;
  logic [AW-1:0]     ex_mem_rd, mem_wb_rd;
  logic              ex_mem_regwrite, mem_wb_regwrite;
  logic              stall, busy;
  logic [NSRC*2-1:0] fwd_sel;
  logic [31:0]       stall_cycles;

  hazard_fwd_unit #(
    .NREG     (32),
    .ZERO_REG (31),
    .NSRC     (2),
    .MAXLAT   (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_src          (id_src),
    .id_src_used     (id_src_used),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_lat          (id_lat),
    .flush           (flush),
    .ex_src          (ex_src),
    .ex_mem_rd       (ex_mem_rd),
    .mem_wb_rd       (mem_wb_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_regwrite (mem_wb_regwrite),
    .stall           (stall),
    .fwd_sel         (fwd_sel),
    .busy            (busy),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic        busy;
    logic [3:0]  fwd;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic [AW-1:0] src0, src1;
    logic [AW-1:0] exm_rd;
    logic          exm_we;
    logic [AW-1:0] mwb_rd;
    logic          mwb_we;
    logic [3:0]    fwd;
  } fvec_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef HAZARD_STATS_EN
    return model_cnt;
`else
    return 32'd0;
`endif
  endfunction

  // Inputs already driven by caller; expectations go through the scoreboard.
  task automatic cyc(input string name, input logic e_stall, input logic e_busy,
                     input logic [3:0] e_fwd);
    exp_t e;
    e.name = name; e.stall = e_stall; e.busy = e_busy; e.fwd = e_fwd; e.cnt = exp_cnt();
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.name, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
    chk({e.name, ".busy"},  {31'd0, busy},  {31'd0, e.busy});
    chk({e.name, ".fwd"},   {28'd0, fwd_sel}, {28'd0, e.fwd});
    chk({e.name, ".cnt"},   stall_cycles, e.cnt);
    @(posedge clk);
    if (e_stall && !flush) model_cnt++;
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_src = '0; id_src_used = '0; id_rd = '0;
    id_regwrite = 1'b0; id_lat = '0; flush = 1'b0;
  endtask

  task automatic produce(input logic [AW-1:0] rd, input logic [LW-1:0] lat);
    id_valid = 1'b1; id_src_used = '0; id_src = '0;
    id_rd = rd; id_regwrite = 1'b1; id_lat = lat; flush = 1'b0;
  endtask

  task automatic consume(input logic [AW-1:0] s0, input logic [1:0] used);
    id_valid = 1'b1; id_src = {s0, s0}; id_src_used = used;
    id_rd = 5'd20; id_regwrite = 1'b0; id_lat = '0; flush = 1'b0;
  endtask

  fvec_t fv[8];

  initial begin
    fv[0] = '{5'd0,  5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 4'b0000};
    fv[1] = '{5'd3,  5'd3,  5'd3,  1'b1, 5'd3,  1'b1, 4'b1010};
    fv[2] = '{5'd31, 5'd31, 5'd31, 1'b1, 5'd31, 1'b1, 4'b0000};
    fv[3] = '{5'd4,  5'd6,  5'd4,  1'b1, 5'd6,  1'b1, 4'b0110};
    fv[4] = '{5'd3,  5'd5,  5'd3,  1'b0, 5'd3,  1'b1, 4'b0001};
    fv[5] = '{5'd2,  5'd3,  5'd3,  1'b1, 5'd3,  1'b0, 4'b1000};
    fv[6] = '{5'd12, 5'd12, 5'd12, 1'b0, 5'd12, 1'b0, 4'b0000};
    fv[7] = '{5'd7,  5'd31, 5'd31, 1'b1, 5'd7,  1'b1, 4'b0001};

    reset = 1'b0;
    idle();
    ex_src = '0; ex_mem_rd = '0; mem_wb_rd = '0;
    ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0;
    #1;
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.busy",  {31'd0, busy},  32'd0);
    chk("rst.fwd",   {28'd0, fwd_sel}, 32'd0);
    chk("rst.cnt",   stall_cycles, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      ex_src = {fv[i].src1, fv[i].src0};
      ex_mem_rd = fv[i].exm_rd; ex_mem_regwrite = fv[i].exm_we;
      mem_wb_rd = fv[i].mwb_rd; mem_wb_regwrite = fv[i].mwb_we;
      cyc($sformatf("fvec%0d", i), 1'b0, 1'b0, fv[i].fwd);
    end
    ex_src = '0; ex_mem_rd = '0; mem_wb_rd = '0;
    ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0;

    // Load-use: LDUR X1 then dependent ADD, then ADD in EX sees X1 in MEM_WB
    produce(5'd1, 3'd1);      cyc("ld.issue", 1'b0, 1'b0, 4'b0000);
    consume(5'd1, 2'b01);     cyc("ld.use0",  1'b1, 1'b1, 4'b0000);
                              cyc("ld.use1",  1'b0, 1'b0, 4'b0000);
    idle();
    ex_src = {5'd0, 5'd1}; mem_wb_rd = 5'd1; mem_wb_regwrite = 1'b1;
                              cyc("ld.fwd",   1'b0, 1'b0, 4'b0001);
    ex_src = '0; mem_wb_rd = '0; mem_wb_regwrite = 1'b0;

    // MUL latency 3 to X5, consumer via operand 1
    produce(5'd5, 3'd3);      cyc("mul.issue", 1'b0, 1'b0, 4'b0000);
    consume(5'd5, 2'b10);
    for (int i = 0; i < 3; i++) cyc($sformatf("mul.st%0d", i), 1'b1, 1'b1, 4'b0000);
                              cyc("mul.go",   1'b0, 1'b0, 4'b0000);
    idle();

    // WAW: younger lat=0 writer replaces older lat=3
    produce(5'd2, 3'd3);      cyc("waw.a",    1'b0, 1'b0, 4'b0000);
    produce(5'd2, 3'd0);      cyc("waw.b",    1'b0, 1'b1, 4'b0000);
    consume(5'd2, 2'b01);     cyc("waw.use",  1'b0, 1'b0, 4'b0000);
    idle();

    // Flush during stall: squashed writer of X6 never enters
    produce(5'd1, 3'd3);      cyc("fl.issue", 1'b0, 1'b0, 4'b0000);
    consume(5'd1, 2'b01); id_rd = 5'd6; id_regwrite = 1'b1; id_lat = 3'd2;
    flush = 1'b1;             cyc("fl.s0",    1'b1, 1'b1, 4'b0000);
    flush = 1'b0;             cyc("fl.s1",    1'b1, 1'b1, 4'b0000);
    flush = 1'b1;             cyc("fl.s2",    1'b1, 1'b1, 4'b0000);
                              cyc("fl.gone",  1'b0, 1'b0, 4'b0000);
    idle();                   cyc("fl.idle",  1'b0, 1'b0, 4'b0000);

    // Self-dependency stalls only on the older count
    produce(5'd7, 3'd2); id_src = {5'd0, 5'd7}; id_src_used = 2'b01;
                              cyc("self.iss", 1'b0, 1'b0, 4'b0000);
    consume(5'd7, 2'b01);     cyc("self.s0",  1'b1, 1'b1, 4'b0000);
                              cyc("self.s1",  1'b1, 1'b1, 4'b0000);
                              cyc("self.go",  1'b0, 1'b0, 4'b0000);
    idle();

    // Zero register is never pending
    produce(5'd31, 3'd3);     cyc("zr.issue", 1'b0, 1'b0, 4'b0000);
    consume(5'd31, 2'b11);    cyc("zr.use",   1'b0, 1'b0, 4'b0000);
    idle();

    // Latency above MAXLAT clamps to 4
    produce(5'd8, 3'd7);      cyc("clamp.iss", 1'b0, 1'b0, 4'b0000);
    consume(5'd8, 2'b01);
    for (int i = 0; i < 4; i++) cyc($sformatf("clamp.st%0d", i), 1'b1, 1'b1, 4'b0000);
                              cyc("clamp.go", 1'b0, 1'b0, 4'b0000);
    idle();

    // Asynchronous reset while stalled
    produce(5'd9, 3'd4);      cyc("ar.issue", 1'b0, 1'b0, 4'b0000);
    consume(5'd9, 2'b01);     cyc("ar.s0",    1'b1, 1'b1, 4'b0000);
    #2;
    reset = 1'b0;
    model_cnt = 0;
    #1;
    chk("ar.stall", {31'd0, stall}, 32'd0);
    chk("ar.busy",  {31'd0, busy},  32'd0);
    chk("ar.cnt",   stall_cycles, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
                              cyc("ar.after", 1'b0, 1'b0, 4'b0000);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
